aes_round_sched: RTL and testbench

//  Iterative AES encryption round sequencer. Accepts one 128-bit block and a key-size mode,

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_round.sv | 51 +++++
 rtl/aes_round_sched.sv | 96 +++++++++
 tb/tb_aes_round_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES round scheduler.
// Contents: round counts, block/counter widths, scheduler state enum,
//           state-byte slice helper, xtime, GF multiply, S-box.
package aes_pkg;

   localparam int unsigned NR_128 = 10;
   localparam int unsigned NR_256 = 14;
   localparam int unsigned BLK_W  = 128;
   localparam int unsigned RND_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   // LSB position of byte (row, col); byte0 sits at [127:120], column-major.
   function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
      return BLK_W - 8 - 8 * (4 * col + row);
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (b^254, which maps 0 to 0) plus the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      logic [7:0] p;
      inv = 8'h01;
      p   = b;
      for (int i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES encryption round: SubBytes -> ShiftRows -> MixColumns
// (bypassed when last) -> AddRoundKey.
// Ports: state (round input), rk (round key), last (skip MixColumns),
//        result_c (round output, combinational).
module aes_round
   import aes_pkg::*;
(
   input  logic [BLK_W-1:0] state,
   input  logic [BLK_W-1:0] rk,
   input  logic             last,
   output logic [BLK_W-1:0] result_c
);

   logic [BLK_W-1:0] sb;
   logic [BLK_W-1:0] sr;
   logic [BLK_W-1:0] mc;

   // SubBytes: position-independent, one S-box per byte.
   for (genvar i = 0; i < 16; i++) begin : g_sbox
      assign sb[8*i +: 8] = sbox(state[8*i +: 8]);
   end

   // ShiftRows: row r rotates left by r columns.
   for (genvar c = 0; c < 4; c++) begin : g_col_sr
      for (genvar r = 0; r < 4; r++) begin : g_row_sr
         localparam int unsigned DST = byte_lsb(r, c);
         localparam int unsigned SRC = byte_lsb(r, (c + r) % 4);
         assign sr[DST +: 8] = sb[SRC +: 8];
      end
   end

   // MixColumns: each column multiplied by the circulant {02,03,01,01}.
   for (genvar c = 0; c < 4; c++) begin : g_col_mc
      localparam int unsigned L0 = byte_lsb(0, c);
      localparam int unsigned L1 = byte_lsb(1, c);
      localparam int unsigned L2 = byte_lsb(2, c);
      localparam int unsigned L3 = byte_lsb(3, c);
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[L0 +: 8];
      assign a1 = sr[L1 +: 8];
      assign a2 = sr[L2 +: 8];
      assign a3 = sr[L3 +: 8];
      assign mc[L0 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[L1 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[L2 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[L3 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

   assign result_c = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES encryption sequencer: one block in, initial AddRoundKey,
// then Nr rounds (10 or 14) through aes_round, ciphertext held until taken.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_block/mode block input;
//        rk_idx/rk round-key fetch; out_valid/out_ready/out_block ciphertext; busy.
module aes_round_sched
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_block,
   input  logic             mode,
   output logic [RND_W-1:0] rk_idx,
   input  logic [BLK_W-1:0] rk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_block,
   output logic             busy
);

   fsm_t             fsm, fsm_nxt;
   logic [BLK_W-1:0] state, state_nxt;
   logic [BLK_W-1:0] round_res_c;
   logic [RND_W-1:0] round, round_nxt;
   logic [RND_W-1:0] nr_q, nr_nxt;
   logic             last_c;

   assign last_c = (round == nr_q);

   aes_round u_round (
      .state    (state),
      .rk       (rk),
      .last     (last_c),
      .result_c (round_res_c)
   );

   // Next-state logic. round returns to 0 outside RUN so it can drive rk_idx directly.
   always_comb begin
      fsm_nxt   = fsm;
      state_nxt = state;
      round_nxt = round;
      nr_nxt    = nr_q;
      case (fsm)
         IDLE: begin
            if (in_valid && in_ready) begin
               state_nxt = in_block ^ rk;
               nr_nxt    = mode ? RND_W'(NR_256) : RND_W'(NR_128);
               round_nxt = RND_W'(1);
               fsm_nxt   = RUN;
            end
         end
         RUN: begin
            state_nxt = round_res_c;
            if (last_c) begin
               round_nxt = '0;
               fsm_nxt   = DONE;
            end else begin
               round_nxt = round + RND_W'(1);
            end
         end
         DONE: begin
            if (out_ready) fsm_nxt = IDLE;
         end
         default: begin
            fsm_nxt   = IDLE;
            round_nxt = '0;
         end
      endcase
   end

   // State and output registers; handshake flags decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= IDLE;
         state     <= '0;
         round     <= '0;
         nr_q      <= RND_W'(NR_128);
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         fsm       <= fsm_nxt;
         state     <= state_nxt;
         round     <= round_nxt;
         nr_q      <= nr_nxt;
         in_ready  <= (fsm_nxt == IDLE);
         out_valid <= (fsm_nxt == DONE);
         busy      <= (fsm_nxt != IDLE);
      end
   end

   assign rk_idx    = round;
   assign out_block = state;

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: FIPS-197 vectors, randomized blocks
// against a behavioural AES model, and multi-cycle handshake/reset corner cases.
module tb_aes_round_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic         mode;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic         busy;

   always #5 clk = ~clk;

   aes_round_sched dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_block  (in_block),
      .mode      (mode),
      .rk_idx    (rk_idx),
      .rk        (rk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_block (out_block),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [7:0]   sbox_t [256];
   logic [127:0] rk_tab [16];
   int           cur_nr = 10;

   always_comb rk = rk_tab[rk_idx];

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box by walking the GF(2^8) generator 3 and its inverse in lockstep.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   // Key storage: FIPS-197 key expansion; 128-bit keys are left-aligned in key.
   task automatic load_key(input logic [255:0] key, input logic m);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, nr, nw;
      nk = m ? 8 : 4;
      nr = m ? 14 : 10;
      nw = 4 * (nr + 1);
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subword({t[23:0], t[31:24]});
            t[31:24] = t[31:24] ^ rc;
            rc = mul2(rc);
         end else if (nk == 8 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      cur_nr = nr;
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] k, res;
      k = rk_tab[0];
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
      for (int r = 1; r <= cur_nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c + w] = t[4*((c + w) % 4) + w];
         if (r < cur_nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
               s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
            end
         end
         k = rk_tab[r];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Handshake flags must never overlap; rk_idx stays within the key table.
   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if ((in_ready && out_valid) || rk_idx > 4'd14) begin
            n_fail++;
            $display("FAIL invariant: in_ready=%b out_valid=%b rk_idx=%0d", in_ready, out_valid, rk_idx);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 30 && !in_ready; i++) step();
      check("in_ready_before_offer", 128'(in_ready), 128'(1));
   endtask

   task automatic accept_block(input logic [127:0] pt, input logic m);
      wait_ready();
      in_valid = 1'b1;
      in_block = pt;
      mode     = m;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit rk_ok);
      lat   = 0;
      rk_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (int'(rk_idx) != lat + 1) rk_ok = 1'b0;
         step();
         lat++;
      end
      if (int'(rk_idx) != 0) rk_ok = 1'b0;
   endtask

   task automatic release_output();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("in_ready_after_handshake", 128'(in_ready), 128'(1));
      check("out_valid_after_handshake", 128'(out_valid), 128'(0));
   endtask

   // Full block: key load, accept, latency, rk_idx sequence, ciphertext, release.
   task automatic run_block(input string name, input logic [255:0] key, input logic m,
                            input logic [127:0] pt, input logic [127:0] exp, input bit scramble);
      int lat;
      bit rk_ok;
      load_key(key, m);
      wait_ready();
      check({name, "_rk_idx_idle"}, 128'(rk_idx), 128'(0));
      in_valid = 1'b1;
      in_block = pt;
      mode     = m;
      step();
      in_valid = 1'b0;
      if (scramble) begin
         mode     = ~m;
         in_block = {$urandom, $urandom, $urandom, $urandom};
      end
      wait_done(lat, rk_ok);
      check({name, "_latency"}, 128'(lat), 128'(m ? 14 : 10));
      check({name, "_rk_seq"}, 128'(rk_ok), 128'(1));
      check({name, "_ct"}, out_block, exp);
      release_output();
   endtask

   typedef struct {
      string        name;
      logic [255:0] key;
      logic         m;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   initial begin
      vec_t         vecs [3];
      logic [127:0] held, pt2, exp2, pt_r;
      logic [255:0] key_r;
      logic         m_r;
      int           lat, nout;
      int           out_cyc [2];
      logic [127:0] out_blk [2];
      bit           rk_ok, second_offer;

      vecs[0] = '{"c1_aes128", KEY_C1, 1'b0, PT_C, CT_C1};
      vecs[1] = '{"c3_aes256", 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  1'b1, PT_C, 128'h8ea2b7ca516745bfeafc49904b496089};
      vecs[2] = '{"b_aes128", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
                  128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};

      build_sbox();
      for (int r = 0; r < 16; r++) rk_tab[r] = 128'h0;
      rst = 1'b1; in_valid = 1'b0; in_block = '0; mode = 1'b0; out_ready = 1'b0;
      step();
      step();
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_rk_idx", 128'(rk_idx), 128'(0));
      check("rst_out_block", out_block, 128'h0);
      rst = 1'b0;
      step();

      // Known-answer vectors.
      for (int i = 0; i < 3; i++)
         run_block(vecs[i].name, vecs[i].key, vecs[i].m, vecs[i].pt, vecs[i].ct, 1'b0);

      // Randomized blocks against the model.
      for (int i = 0; i < 6; i++) begin
         key_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         m_r   = 1'($urandom_range(0, 1));
         pt_r  = {$urandom, $urandom, $urandom, $urandom};
         load_key(key_r, m_r);
         run_block($sformatf("rand%0d", i), key_r, m_r, pt_r, aes_ref(pt_r), 1'b0);
      end

      // Mode and block change while in flight.
      run_block("mode_change", KEY_C1, 1'b0, PT_C, CT_C1, 1'b1);

      // Backpressure in DONE, with an in_valid pulse that must be ignored.
      load_key(KEY_C1, 1'b0);
      accept_block(PT_C, 1'b0);
      wait_done(lat, rk_ok);
      held = out_block;
      check("bp_ct", held, CT_C1);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            in_valid = 1'b1;
            in_block = {$urandom, $urandom, $urandom, $urandom};
         end
         step();
         in_valid = 1'b0;
         check($sformatf("bp_stable%0d", k), out_block, held);
         check($sformatf("bp_in_ready%0d", k), 128'(in_ready), 128'(0));
         check($sformatf("bp_out_valid%0d", k), 128'(out_valid), 128'(1));
      end
      release_output();
      step();
      step();
      check("bp_no_restart", 128'(busy), 128'(0));

      // Back-to-back with in_valid held and out_ready high.
      load_key(KEY_C1, 1'b0);
      pt2  = {$urandom, $urandom, $urandom, $urandom};
      exp2 = aes_ref(pt2);
      wait_ready();
      in_valid  = 1'b1;
      in_block  = PT_C;
      mode      = 1'b0;
      out_ready = 1'b1;
      step();
      in_block = pt2;
      nout = 0;
      second_offer = 1'b0;
      out_cyc[0] = -1; out_cyc[1] = -1;
      out_blk[0] = '0; out_blk[1] = '0;
      for (int c = 0; c < 40 && nout < 2; c++) begin
         if (out_valid) begin
            out_cyc[nout] = c;
            out_blk[nout] = out_block;
            nout++;
         end
         if (nout == 1 && in_ready) second_offer = 1'b1;
         step();
         if (second_offer) in_valid = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", 128'(nout), 128'(2));
      check("b2b_lat0", 128'(out_cyc[0]), 128'(10));
      check("b2b_lat1", 128'(out_cyc[1]), 128'(22));
      check("b2b_ct0", out_blk[0], CT_C1);
      check("b2b_ct1", out_blk[1], exp2);
      step();
      step();

      // Reset at round 5 aborts the block.
      load_key(KEY_C1, 1'b0);
      accept_block(PT_C, 1'b0);
      for (int i = 0; i < 20 && rk_idx != 4'd5; i++) step();
      check("rst5_reached_round5", 128'(rk_idx), 128'(5));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst5_in_ready", 128'(in_ready), 128'(1));
      check("rst5_out_valid", 128'(out_valid), 128'(0));
      check("rst5_out_block", out_block, 128'h0);
      check("rst5_busy", 128'(busy), 128'(0));
      run_block("after_rst", KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
